// File: rtl/maxflow_l1_rd_arb.sv
// Round-robin arbiter sharing one L1 AXI read channel among N_PORTS task cores.
// AR requests are serialised with the winner's index in ARID; R beats are steered back by RID.
module maxflow_l1_rd_arb #(
   parameter int N_PORTS = 4,
   parameter int ID_W    = 2
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [N_PORTS-1:0]     s_arvalid,
   output logic [N_PORTS-1:0]     s_arready,
   input  logic [32*N_PORTS-1:0]  s_araddr,
   input  logic [8*N_PORTS-1:0]   s_arlen,
   input  logic [3*N_PORTS-1:0]   s_arsize,
   output logic [N_PORTS-1:0]     s_rvalid,
   input  logic [N_PORTS-1:0]     s_rready,
   output logic [63:0]            s_rdata,
   output logic                   s_rlast,
   output logic [1:0]             s_rresp,
   output logic                   m_axi_l1_V_ARVALID,
   input  logic                   m_axi_l1_V_ARREADY,
   output logic [31:0]            m_axi_l1_V_ARADDR,
   output logic [7:0]             m_axi_l1_V_ARLEN,
   output logic [2:0]             m_axi_l1_V_ARSIZE,
   output logic [ID_W-1:0]        m_axi_l1_V_ARID,
   input  logic                   m_axi_l1_V_RVALID,
   output logic                   m_axi_l1_V_RREADY,
   input  logic [63:0]            m_axi_l1_V_RDATA,
   input  logic                   m_axi_l1_V_RLAST,
   input  logic [ID_W-1:0]        m_axi_l1_V_RID,
   input  logic [1:0]             m_axi_l1_V_RRESP,
   output logic                   err_sticky,
   output logic [N_PORTS-1:0]     outstanding
);

   typedef enum logic {ARB_IDLE, ARB_ISSUE} arbState_t;

   arbState_t r_state, w_stateNext;

   logic [ID_W-1:0]    r_rrPtr;
   logic [ID_W-1:0]    r_arid;
   logic [31:0]        r_araddr;
   logic [7:0]         r_arlen;
   logic [2:0]         r_arsize;
   logic [N_PORTS-1:0] r_outstanding;
   logic               r_errSticky;

   logic [ID_W-1:0]    w_winner;
   logic               w_found;
   logic [31:0]        w_winAddr;
   logic [7:0]         w_winLen;
   logic [2:0]         w_winSize;
   logic [N_PORTS-1:0] w_outNext;
   logic [2**ID_W-1:0] w_eligExt;
   logic [2**ID_W-1:0] w_outExt;
   logic [2**ID_W-1:0] w_rreadyExt;
   logic               w_hit;
   logic               w_arHs;
   logic               w_rLastHs;

   // Vectors widened to the full RID space so unused IDs read as "not outstanding"
   always_comb begin
      w_eligExt   = '0;
      w_outExt    = '0;
      w_rreadyExt = '0;
      w_eligExt[N_PORTS-1:0]   = s_arvalid & ~r_outstanding;
      w_outExt[N_PORTS-1:0]    = r_outstanding;
      w_rreadyExt[N_PORTS-1:0] = s_rready;
   end

   always_comb begin
      logic [ID_W-1:0] idx;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         idx = ID_W'((int'(r_rrPtr) + k) % N_PORTS);
         if (!w_found && w_eligExt[idx]) begin
            w_found  = 1'b1;
            w_winner = idx;
         end
      end
   end

   always_comb begin
      w_winAddr = '0;
      w_winLen  = '0;
      w_winSize = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (w_winner == ID_W'(i)) begin
            w_winAddr = s_araddr[32*i +: 32];
            w_winLen  = s_arlen[8*i +: 8];
            w_winSize = s_arsize[3*i +: 3];
         end
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ARB_IDLE:  if (w_found) w_stateNext = ARB_ISSUE;
         ARB_ISSUE: if (m_axi_l1_V_ARREADY) w_stateNext = ARB_IDLE;
         default:   w_stateNext = ARB_IDLE;
      endcase
   end

   assign m_axi_l1_V_ARVALID = (r_state == ARB_ISSUE);
   assign m_axi_l1_V_ARADDR  = r_araddr;
   assign m_axi_l1_V_ARLEN   = r_arlen;
   assign m_axi_l1_V_ARSIZE  = r_arsize;
   assign m_axi_l1_V_ARID    = r_arid;
   assign w_arHs             = m_axi_l1_V_ARVALID & m_axi_l1_V_ARREADY;

   // Stray beats (unknown or idle RID) are always accepted so the L1 never stalls
   assign w_hit             = w_outExt[m_axi_l1_V_RID];
   assign m_axi_l1_V_RREADY = w_hit ? w_rreadyExt[m_axi_l1_V_RID] : 1'b1;
   assign w_rLastHs         = m_axi_l1_V_RVALID & m_axi_l1_V_RREADY & m_axi_l1_V_RLAST & w_hit;
   assign s_rdata           = m_axi_l1_V_RDATA;
   assign s_rlast           = m_axi_l1_V_RLAST;
   assign s_rresp           = m_axi_l1_V_RRESP;
   assign err_sticky        = r_errSticky;
   assign outstanding       = r_outstanding;

   always_comb begin
      s_arready = '0;
      s_rvalid  = '0;
      w_outNext = r_outstanding;
      for (int i = 0; i < N_PORTS; i++) begin
         s_arready[i] = w_arHs & (r_arid == ID_W'(i));
         s_rvalid[i]  = m_axi_l1_V_RVALID & w_hit & (m_axi_l1_V_RID == ID_W'(i));
         if (w_arHs && (r_arid == ID_W'(i)))
            w_outNext[i] = 1'b1;
         if (w_rLastHs && (m_axi_l1_V_RID == ID_W'(i)))
            w_outNext[i] = 1'b0;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n)
         r_state <= ARB_IDLE;
      else
         r_state <= w_stateNext;
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_rrPtr       <= '0;
         r_arid        <= '0;
         r_araddr      <= '0;
         r_arlen       <= '0;
         r_arsize      <= '0;
         r_outstanding <= '0;
         r_errSticky   <= 1'b0;
      end else begin
         r_outstanding <= w_outNext;
         if (r_state == ARB_IDLE && w_found) begin
            r_arid   <= w_winner;
            r_araddr <= w_winAddr;
            r_arlen  <= w_winLen;
            r_arsize <= w_winSize;
         end
         if (w_arHs)
            r_rrPtr <= (r_arid == ID_W'(N_PORTS - 1)) ? '0 : r_arid + ID_W'(1);
         if (m_axi_l1_V_RVALID && !w_hit)
            r_errSticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_maxflow_l1_rd_arb.sv
// Self-checking bench for maxflow_l1_rd_arb: directed literal checks followed by randomized
// traffic against a transaction-level model of the arbiter and a simple L1 responder.
module tb_maxflow_l1_rd_arb;
   localparam int N  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstN = 1'b0;
   logic [N-1:0]    sArvalid = '0, sArready, sRvalid, sRready = '0;
   logic [32*N-1:0] sAraddr = '0;
   logic [8*N-1:0]  sArlen = '0;
   logic [3*N-1:0]  sArsize = '0;
   logic [63:0]     sRdata;
   logic            sRlast;
   logic [1:0]      sRresp;
   logic            mArvalid, mArready = 1'b0;
   logic [31:0]     mAraddr;
   logic [7:0]      mArlen;
   logic [2:0]      mArsize;
   logic [IW-1:0]   mArid;
   logic            mRvalid = 1'b0, mRready;
   logic [63:0]     mRdata = '0;
   logic            mRlast = 1'b0;
   logic [IW-1:0]   mRid = '0;
   logic [1:0]      mRresp = '0;
   logic            errSticky;
   logic [N-1:0]    outst;

   maxflow_l1_rd_arb #(.N_PORTS(N), .ID_W(IW)) dut (
      .ap_clk(clk), .ap_rst_n(rstN),
      .s_arvalid(sArvalid), .s_arready(sArready), .s_araddr(sAraddr),
      .s_arlen(sArlen), .s_arsize(sArsize),
      .s_rvalid(sRvalid), .s_rready(sRready), .s_rdata(sRdata),
      .s_rlast(sRlast), .s_rresp(sRresp),
      .m_axi_l1_V_ARVALID(mArvalid), .m_axi_l1_V_ARREADY(mArready),
      .m_axi_l1_V_ARADDR(mAraddr), .m_axi_l1_V_ARLEN(mArlen),
      .m_axi_l1_V_ARSIZE(mArsize), .m_axi_l1_V_ARID(mArid),
      .m_axi_l1_V_RVALID(mRvalid), .m_axi_l1_V_RREADY(mRready),
      .m_axi_l1_V_RDATA(mRdata), .m_axi_l1_V_RLAST(mRlast),
      .m_axi_l1_V_RID(mRid), .m_axi_l1_V_RRESP(mRresp),
      .err_sticky(errSticky), .outstanding(outst)
   );

   int passCnt = 0;
   int checkCnt = 0;

   // Reference model: which cores own a burst, who holds the grant (-1 = none), pointer
   bit          modelValid = 1'b0;
   bit          mdlOut[N];
   int          mdlRr, mdlGrant;
   logic [31:0] mdlAddr;
   logic [7:0]  mdlLen;
   logic [2:0]  mdlSize;
   int          mdlId;
   bit          mdlErr;

   bit          arHs;
   int          arHsId;
   int          arHsLen;
   logic [N-1:0] coreHs = '0;
   bit          rHs;

   bit          reqActive[N];
   logic [31:0] reqAddr[N];
   logic [7:0]  reqLen[N];
   logic [2:0]  reqSize[N];
   int          l1Beats[N];
   bit          rDriving;
   int          curRid;

   task automatic checkValue(string name, logic [63:0] act, logic [63:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic checkOutput();
      logic [N-1:0] expArready, expRvalid, expOut;
      bit hit, expRready;
      if (!modelValid) return;
      hit = mdlOut[mRid];
      expRready = hit ? sRready[mRid] : 1'b1;
      for (int i = 0; i < N; i++) begin
         expArready[i] = (mdlGrant == i) && mArready;
         expRvalid[i]  = mRvalid && hit && (int'(mRid) == i);
         expOut[i]     = mdlOut[i];
      end
      checkValue("arvalid", mArvalid, mdlGrant >= 0);
      checkValue("araddr", mAraddr, mdlAddr);
      checkValue("arlen", mArlen, mdlLen);
      checkValue("arsize", mArsize, mdlSize);
      checkValue("arid", mArid, mdlId);
      checkValue("s_arready", sArready, expArready);
      checkValue("s_rvalid", sRvalid, expRvalid);
      checkValue("rready", mRready, expRready);
      checkValue("rpass", {sRdata[60:0], sRlast, sRresp}, {mRdata[60:0], mRlast, mRresp});
      checkValue("outstanding", outst, expOut);
      checkValue("err_sticky", errSticky, mdlErr);
      arHs    = (mdlGrant >= 0) && mArready;
      arHsId  = mdlGrant;
      arHsLen = int'(mdlLen) + 1;
      coreHs  = expArready & sArvalid;
      rHs     = mRvalid && expRready;
   endtask

   task automatic updateModel();
      bit newOut[N];
      bit found;
      int idx;
      if (!rstN) begin
         modelValid = 1'b1;
         foreach (mdlOut[i]) mdlOut[i] = 1'b0;
         mdlRr = 0; mdlGrant = -1; mdlAddr = '0; mdlLen = '0; mdlSize = '0; mdlId = 0; mdlErr = 1'b0;
         return;
      end
      if (!modelValid) return;
      newOut = mdlOut;
      if (mdlGrant >= 0) begin
         if (mArready) begin
            newOut[mdlGrant] = 1'b1;
            mdlRr = (mdlGrant + 1) % N;
            mdlGrant = -1;
         end
      end else begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (mdlRr + k) % N;
            if (!found && sArvalid[idx] && !mdlOut[idx]) begin
               found = 1'b1;
               mdlGrant = idx; mdlId = idx;
               mdlAddr = sAraddr[32*idx +: 32];
               mdlLen  = sArlen[8*idx +: 8];
               mdlSize = sArsize[3*idx +: 3];
            end
         end
      end
      if (mRvalid) begin
         if (!mdlOut[mRid]) mdlErr = 1'b1;
         else if (sRready[mRid] && mRlast) newOut[mRid] = 1'b0;
      end
      mdlOut = newOut;
   endtask

   task automatic stepCycle();
      #2;
      checkOutput();
      @(posedge clk);
      #1;
      updateModel();
   endtask

   task automatic applyStimulus();
      int cand[$];
      for (int i = 0; i < N; i++) begin
         if (coreHs[i]) reqActive[i] = 1'b0;
         if (!reqActive[i] && $urandom_range(3) == 0) begin
            reqActive[i] = 1'b1;
            reqAddr[i] = $urandom;
            reqLen[i]  = 8'($urandom_range(3));
            reqSize[i] = 3'($urandom_range(3));
         end
         sArvalid[i] = reqActive[i];
         sAraddr[32*i +: 32] = reqAddr[i];
         sArlen[8*i +: 8]    = reqLen[i];
         sArsize[3*i +: 3]   = reqSize[i];
      end
      if (arHs) l1Beats[arHsId] = arHsLen;
      if (rDriving && rHs) begin
         l1Beats[curRid]--;
         rDriving = 1'b0;
      end
      if (!rDriving && $urandom_range(1) == 1) begin
         for (int i = 0; i < N; i++) if (l1Beats[i] > 0) cand.push_back(i);
         if (cand.size() > 0) begin
            rDriving = 1'b1;
            curRid = cand[$urandom_range(cand.size() - 1)];
            mRdata = {$urandom, $urandom};
            mRresp = 2'($urandom_range(3));
         end
      end
      mRvalid  = rDriving;
      mRid     = IW'(curRid);
      mRlast   = rDriving && (l1Beats[curRid] == 1);
      mArready = ($urandom_range(3) != 0);
      sRready  = N'($urandom);
   endtask

   initial begin
      stepCycle();
      rstN = 1'b1;
      checkValue("reset_outstanding", outst, 4'b0000);
      checkValue("reset_arvalid", mArvalid, 1'b0);
      checkValue("reset_err", errSticky, 1'b0);
      checkValue("reset_arready", sArready, 4'b0000);

      // Single request from core 0
      sArvalid = 4'b0001; sAraddr[31:0] = 32'h100; sArlen[7:0] = 8'd1; sArsize[2:0] = 3'd3;
      stepCycle();
      checkValue("t1_arvalid", mArvalid, 1'b1);
      checkValue("t1_araddr", mAraddr, 32'h100);
      checkValue("t1_arlen", mArlen, 8'd1);
      checkValue("t1_arid", mArid, 2'd0);
      mArready = 1'b1;
      #1 checkValue("t1_s_arready", sArready, 4'b0001);
      stepCycle();
      sArvalid = '0; mArready = 1'b0;
      checkValue("t1_out_set", outst, 4'b0001);
      mRvalid = 1'b1; mRid = 2'd0; mRdata = 64'hA5; sRready = 4'b1111;
      #1 checkValue("t1_beat0_rvalid", sRvalid, 4'b0001);
      stepCycle();
      mRlast = 1'b1;
      stepCycle();
      mRvalid = 1'b0; mRlast = 1'b0;
      checkValue("t1_out_clear", outst, 4'b0000);

      // Stray RID
      mRvalid = 1'b1; mRid = 2'd2;
      #1 checkValue("stray_rready", mRready, 1'b1);
      checkValue("stray_rvalid", sRvalid, 4'b0000);
      stepCycle();
      mRvalid = 1'b0;
      checkValue("stray_err", errSticky, 1'b1);
      stepCycle();
      checkValue("stray_err_held", errSticky, 1'b1);

      // Grant held stable while ARREADY is low
      sArvalid = 4'b0100; sAraddr[95:64] = 32'h2000; sAraddr[63:32] = 32'h1000;
      stepCycle();
      sArvalid = 4'b0110;
      repeat (5) begin
         stepCycle();
         checkValue("hold_arid", mArid, 2'd2);
         checkValue("hold_araddr", mAraddr, 32'h2000);
         checkValue("hold_arready", sArready, 4'b0000);
      end
      mArready = 1'b1;
      stepCycle();
      sArvalid = 4'b0010;
      checkValue("hold_out", outst, 4'b0100);
      stepCycle();
      checkValue("next_arid", mArid, 2'd1);
      stepCycle();
      sArvalid = '0;
      checkValue("both_out", outst, 4'b0110);

      // Reset with bursts in flight, then pointer must restart at core 0
      rstN = 1'b0;
      stepCycle();
      rstN = 1'b1;
      checkValue("rst_outstanding", outst, 4'b0000);
      checkValue("rst_arvalid", mArvalid, 1'b0);
      checkValue("rst_err", errSticky, 1'b0);
      sArvalid = 4'b1111; mArready = 1'b0;
      stepCycle();
      checkValue("rst_rr_arid", mArid, 2'd0);

      sArvalid = '0; rstN = 1'b0;
      stepCycle();
      rstN = 1'b1;
      foreach (reqActive[i]) begin
         reqActive[i] = 1'b0; reqAddr[i] = '0; reqLen[i] = '0; reqSize[i] = '0; l1Beats[i] = 0;
      end
      rDriving = 1'b0; curRid = 0; arHs = 1'b0; rHs = 1'b0; coreHs = '0;
      repeat (3000) begin
         applyStimulus();
         stepCycle();
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
